// File: rtl/score_display_mux_if.sv
// score_display_mux_if: BCD digit inputs and multiplexed 7-segment display outputs
interface score_display_mux_if;
    logic [3:0] tens_i;
    logic [3:0] ones_i;
    logic [6:0] seg_o;
    logic [1:0] dig_o;
    logic       frame_o;

    modport master (output tens_i, ones_i, input seg_o, dig_o, frame_o);
    modport slave  (input tens_i, ones_i, output seg_o, dig_o, frame_o);
endinterface

// File: rtl/score_display_mux.sv
// score_display_mux: 2-digit time-multiplexed 7-segment driver with per-frame shadow capture (option: LEADING_ZERO_BLANK_EN)
module score_display_mux #(
    parameter int REFRESH_DIV = 1000
) (
    input logic               clk_i,
    input logic               rst_ni,
    score_display_mux_if.slave bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          slot;
    logic [3:0]    shadow_tens;
    logic [3:0]    shadow_ones;
    logic [3:0]    digit;
    logic          last;
    logic          blank;
    logic [6:0]    seg_next;
    logic [1:0]    dig_next;

    assign last        = cnt == CW'(REFRESH_DIV - 1);
    assign bus.frame_o = last && slot;
    assign digit       = slot ? shadow_tens : shadow_ones;

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = slot && shadow_tens == 4'd0;
`else
    assign blank = 1'b0;
`endif

    // Segment pattern of the digit shown in the current slot; non-BCD shows a dash
    always_comb begin
        seg_next = 7'h40;
        case (digit)
            4'd0: seg_next = 7'h3F;
            4'd1: seg_next = 7'h06;
            4'd2: seg_next = 7'h5B;
            4'd3: seg_next = 7'h4F;
            4'd4: seg_next = 7'h66;
            4'd5: seg_next = 7'h6D;
            4'd6: seg_next = 7'h7D;
            4'd7: seg_next = 7'h07;
            4'd8: seg_next = 7'h7F;
            4'd9: seg_next = 7'h6F;
            default: seg_next = 7'h40;
        endcase
        if (blank) seg_next = 7'h00;
    end

    // First cycle of every slot is blanked so the previous digit cannot ghost
    assign dig_next = (cnt == '0 || blank) ? 2'b00 : (slot ? 2'b10 : 2'b01);

    // Prescaler, slot toggle and once-per-frame shadow reload
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt         <= '0;
            slot        <= 1'b0;
            shadow_tens <= 4'd0;
            shadow_ones <= 4'd0;
        end else begin
            cnt  <= last ? '0 : cnt + CW'(1);
            slot <= slot ^ last;
            if (last && slot) begin
                shadow_tens <= bus.tens_i;
                shadow_ones <= bus.ones_i;
            end
        end
    end

    // Registered display drive, one cycle behind the scan state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.seg_o <= 7'h00;
            bus.dig_o <= 2'b00;
        end else begin
            bus.seg_o <= seg_next;
            bus.dig_o <= dig_next;
        end
    end
endmodule

// File: tb/tb_score_display_mux.sv
// tb_score_display_mux: scoreboard bench for score_display_mux with REFRESH_DIV=4
module tb_score_display_mux;
    localparam int R = 4;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] dig;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    int       m_cnt;
    logic     m_slot;
    logic [3:0] m_sh_t, m_sh_o;
    logic [6:0] tab [16];

    score_display_mux_if bus();

    score_display_mux #(.REFRESH_DIV(R)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_slot = 1'b0;
        m_sh_t = 4'd0;
        m_sh_o = 4'd0;
        sb.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_seg"}, 8'(bus.seg_o), 8'h00);
        check({tag, "_dig"}, 8'(bus.dig_o), 8'h00);
        check({tag, "_frame"}, 8'(bus.frame_o), 8'h00);
    endtask

    task automatic tick();
        exp_t e;
        logic [3:0] d;
        logic blank;
        check("frame", 8'(bus.frame_o), 8'(m_slot && m_cnt == R - 1));
        d = m_slot ? m_sh_t : m_sh_o;
`ifdef LEADING_ZERO_BLANK_EN
        blank = m_slot && m_sh_t == 4'd0;
`else
        blank = 1'b0;
`endif
        e.seg = blank ? 7'h00 : tab[d];
        e.dig = (m_cnt == 0 || blank) ? 2'b00 : (m_slot ? 2'b10 : 2'b01);
        sb.push_back(e);
        @(posedge clk);
        if (m_slot && m_cnt == R - 1) begin
            m_sh_t = bus.tens_i;
            m_sh_o = bus.ones_i;
        end
        if (m_cnt == R - 1) begin
            m_cnt  = 0;
            m_slot = ~m_slot;
        end else begin
            m_cnt++;
        end
        #1;
        e = sb.pop_front();
        check("seg", 8'(bus.seg_o), 8'(e.seg));
        check("dig", 8'(bus.dig_o), 8'(e.dig));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        model_reset();
        bus.tens_i = 4'd4;
        bus.ones_i = 4'd2;
        #1;
        check_zero("rst0");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        rst_n = 1'b1;
        run(16);
        run(2);
        bus.tens_i = 4'd7;
        bus.ones_i = 4'd3;
        run(22);
        bus.tens_i = 4'hF;
        bus.ones_i = 4'hA;
        run(16);
        bus.tens_i = 4'd9;
        bus.ones_i = 4'd9;
        run(16 + 6);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold2");
        end
        rst_n = 1'b1;
        run(8);
        bus.tens_i = 4'd0;
        bus.ones_i = 4'd5;
        run(24);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/score_display_mux.md
Name: score_display_mux

Overview:
Downstream consumer of the binary-to-decimal stage. Takes the tens/ones BCD digits of the scoreboard value and drives a 2-digit, time-multiplexed common-cathode 7-segment display. Digits are captured once per scan frame, so the displayed value never tears. Each digit slot is blanked for one cycle at the slot switch to suppress ghosting.

Parameters:
REFRESH_DIV, 1000, clock cycles per digit slot; legal range >= 2; prescaler width = $clog2(REFRESH_DIV)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous reset, active-low
tens_i  input  4  tens digit (BCD) from binary-to-decimal stage
ones_i  input  4  ones digit (BCD) from binary-to-decimal stage
seg_o  output  7  segment drive, active-high; bit0=a … bit6=g
dig_o  output  2  digit enable, one-hot active-high; 2'b01=ones, 2'b10=tens, 2'b00=all off
frame_o  output  1  single-cycle pulse on the cycle the shadow digits are reloaded

Behaviour:
- State: prescaler cnt (0..REFRESH_DIV-1), slot bit (0=ones, 1=tens), shadow_tens/shadow_ones (4 b each).
- Reset (rst_ni low, async): cnt=0, slot=0, shadows=0, seg_o=7'h00, dig_o=2'b00, frame_o=0. All outputs hold these values while reset is asserted.
- Every clock edge: cnt increments and wraps to 0 after REFRESH_DIV-1. On the wrap, slot toggles.
- Frame boundary is the cycle with cnt==REFRESH_DIV-1 and slot==1. On that edge, shadow_tens<=tens_i and shadow_ones<=ones_i, and frame_o is 1 for exactly that cycle (combinational from state).
- Input changes at any other time do not affect the display until the next frame boundary.
- The first frame after reset therefore displays "00". The first real value is captured at the end of cycle 2*REFRESH_DIV-1.
- Output registers update every edge from the current state (1-cycle latency):
  - seg_o <= decode(slot ? shadow_tens : shadow_ones)
  - dig_o <= (cnt==0) ? 2'b00 : (slot ? 2'b10 : 2'b01) — anti-ghost blanking on the first cycle of each slot.
- Decode table (hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
- Digit values 10..15 are invalid BCD and decode to dash 7'h40 (segment g only).
- Steady state per frame: ones enabled REFRESH_DIV-1 cycles, then tens enabled REFRESH_DIV-1 cycles, with one blank cycle before each.
- Reset asserted mid-scan: immediate return to reset values. Scanning restarts at slot 0, cnt 0, with shadows cleared.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: when shadow_tens==0, the tens slot outputs seg_o=7'h00 and dig_o=2'b00 for the whole slot. Ones slot is unchanged, so value 7 shows as " 7".
- Not defined: tens digit 0 is displayed as 7'h3F, so value 7 shows as "07".
- Timing, frame_o and shadow loading are identical in both builds.

Test Plan:
1. REFRESH_DIV=4, hold rst_ni=0 for 3 cycles with tens_i=4, ones_i=2 -> seg_o=00, dig_o=00, frame_o=0 throughout. After release, first frame shows dig_o 00,01,01,01,00,10,10,10 with seg_o=3F.
2. Continue case 1 -> frame_o high at cycle 7 after release; the following frame shows ones slot seg_o=5B (2) on dig_o=01 and tens slot seg_o=66 (4) on dig_o=10.
3. Change tens_i/ones_i to 7/3 while slot==0 mid-frame -> display stays "42" until the next frame_o pulse, then ones=4F, tens=07.
4. Drive ones_i=4'hA, tens_i=4'hF -> after the frame boundary both slots show seg_o=40.
5. Assert rst_ni low mid tens slot with 9/9 displayed -> seg_o/dig_o go 0 immediately (asynchronously). After release, the first frame shows 3F on both slots.
6. Build with LEADING_ZERO_BLANK_EN, tens_i=0, ones_i=5 -> tens slot dig_o=00, seg_o=00; ones slot seg_o=6D, dig_o=01. Without the macro, tens slot shows 3F on dig_o=10.
